// File: rtl/screen_mem_pkg.sv
// Shared definitions for the screen framebuffer controller.
// Holds default geometry and the controller state encoding.
package screen_mem_pkg;

  localparam int SCREEN_ADDR_W    = 13;
  localparam int SCREEN_DATA_W    = 16;
  localparam int SCREEN_RSP_DEPTH = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } screen_state_e;

endpackage

// File: rtl/screen_rsp_fifo.sv
// Response FIFO holding read data for the SCREEN consumer.
// The caller guarantees it never pushes into a full FIFO.
// The head entry is visible on o_rdat whenever o_empty is low.
module screen_rsp_fifo
  import screen_mem_pkg::*;
#(
  parameter int DEPTH = SCREEN_RSP_DEPTH,
  parameter int WIDTH = SCREEN_DATA_W
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wdat,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_rdat,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Pointer and occupancy bookkeeping; cleared by reset so queued data is dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= ptr_inc(r_wptr);
      if (i_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Data storage carries no reset; validity comes from the occupancy count.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdat;
  end

  assign o_rdat  = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/screen_mem_ctrl.sv
// Framebuffer controller: CPU write port, SCREEN read port with a
// credit-limited response FIFO, single-port synchronous-read RAM.
// Optional build macro SCREEN_MEM_CLEAR_EN: after reset the RAM is
// zero-filled address by address before any access is accepted.
module screen_mem_ctrl
  import screen_mem_pkg::*;
#(
  parameter int ADDR_W    = SCREEN_ADDR_W,
  parameter int DATA_W    = SCREEN_DATA_W,
  parameter int RSP_DEPTH = SCREEN_RSP_DEPTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdat,
  output logic              cpu_rdy,
  input  logic              mem_addr_vld,
  output logic              mem_addr_gnt,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic              mem_dat_vld,
  input  logic              mem_dat_gnt,
  output logic [DATA_W-1:0] mem_dat
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  screen_state_e r_state;
  screen_state_e w_state_nxt;

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_dat_p1;
  logic              r_rd_vld_p1;

  logic              w_init_wr;
  logic              w_init_done;
  logic              w_cpu_wr;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdat;
  logic              w_credit_ok;
  logic              w_rd_acc;
  logic              w_out_pop;
  logic              w_fifo_push;
  logic              w_fifo_pop;
  logic              w_fifo_empty;
  logic [DATA_W-1:0] w_fifo_rdat;
  logic [CNT_W-1:0]  w_fifo_cnt;

`ifdef SCREEN_MEM_CLEAR_EN
  logic [ADDR_W-1:0] r_init_cnt;

  // Clear-address counter walks every word once while in INIT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  r_init_cnt <= '0;
    else if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + ADDR_W'(1);
  end

  assign w_init_wr   = (r_state == ST_INIT);
  assign w_init_done = (r_init_cnt == '1);
`else
  assign w_init_wr   = 1'b0;
  assign w_init_done = 1'b1;
`endif

  // State register; INIT is the reset state and RUN holds until the next reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  // Next state and port handshakes; CPU writes always win the single RAM port.
  always_comb begin
    w_state_nxt  = r_state;
    cpu_rdy      = 1'b0;
    mem_addr_gnt = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (w_init_done) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        cpu_rdy      = 1'b1;
        mem_addr_gnt = !cpu_we && w_credit_ok;
      end
    endcase
  end

  // A read may only be granted if its data is sure to find room in the FIFO.
  assign w_credit_ok = (int'(w_fifo_cnt) + int'(r_rd_vld_p1)) < RSP_DEPTH;
  assign w_rd_acc    = mem_addr_vld && mem_addr_gnt;
  assign w_cpu_wr    = cpu_we && cpu_rdy;
  assign w_ram_we    = w_init_wr || w_cpu_wr;

  // RAM address/data select: clear sweep, then CPU write, else SCREEN read.
  always_comb begin
    w_ram_addr = mem_addr;
    w_ram_wdat = cpu_wdat;
`ifdef SCREEN_MEM_CLEAR_EN
    if (w_init_wr) begin
      w_ram_addr = r_init_cnt;
      w_ram_wdat = '0;
    end else if (cpu_we) begin
      w_ram_addr = cpu_addr;
    end
`else
    if (cpu_we) w_ram_addr = cpu_addr;
`endif
  end

  // ---- stage p0 -> p1: RAM access, one-cycle synchronous read ----
  // Single-port RAM with registered read data.
  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_ram_addr] <= w_ram_wdat;
    r_rd_dat_p1 <= r_mem[w_ram_addr];
  end

  // In-flight flag: read data on r_rd_dat_p1 belongs to an accepted request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rd_vld_p1 <= 1'b0;
    else       r_rd_vld_p1 <= w_rd_acc;
  end

  // ---- stage p1: response queue and output ----
  // When the FIFO is empty the fresh RAM word is shown directly; it is only
  // queued if the consumer does not take it in that same cycle.
  assign mem_dat_vld = !w_fifo_empty || r_rd_vld_p1;
  assign w_out_pop   = mem_dat_vld && mem_dat_gnt;
  assign w_fifo_pop  = !w_fifo_empty && w_out_pop;
  assign w_fifo_push = r_rd_vld_p1 && !(w_fifo_empty && w_out_pop);
  assign mem_dat     = !w_fifo_empty ? w_fifo_rdat :
                       (r_rd_vld_p1 ? r_rd_dat_p1 : '0);

  screen_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W)
  ) u_rsp_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_fifo_push),
    .i_wdat  (r_rd_dat_p1),
    .i_pop   (w_fifo_pop),
    .o_rdat  (w_fifo_rdat),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_cnt)
  );

endmodule

// File: tb/tb_screen_mem_ctrl.sv
// Self-checking bench for screen_mem_ctrl.
// Read data is checked against a scoreboard filled from a reference
// memory model at each granted request; scenario tasks add inline checks.
`timescale 1ns/1ps
module tb_screen_mem_ctrl;

  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 16;
  localparam int RSP_DEPTH = 2;
`ifdef SCREEN_MEM_CLEAR_EN
  localparam int EXP_RDY_CYC = 8192;
`else
  localparam int EXP_RDY_CYC = 1;
`endif

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdat = '0;
  logic              cpu_rdy;
  logic              mem_addr_vld = 1'b0;
  logic              mem_addr_gnt;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic              mem_dat_vld;
  logic              mem_dat_gnt = 1'b1;
  logic [DATA_W-1:0] mem_dat;

  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;

  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] model [int];
  logic [DATA_W-1:0] exp_d;

  always #5 clk = ~clk;

  screen_mem_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdat     (cpu_wdat),
    .cpu_rdy      (cpu_rdy),
    .mem_addr_vld (mem_addr_vld),
    .mem_addr_gnt (mem_addr_gnt),
    .mem_addr     (mem_addr),
    .mem_dat_vld  (mem_dat_vld),
    .mem_dat_gnt  (mem_dat_gnt),
    .mem_dat      (mem_dat)
  );

  // Scoreboard: model writes, queue expected data on grants, compare on pops.
  always @(negedge clk) begin
    if (rstn) begin
      if (mem_dat_vld && mem_dat_gnt) begin
        n_pop++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rd_data: got %h while no read was outstanding", mem_dat);
        end else begin
          exp_d = exp_q.pop_front();
          if (mem_dat !== exp_d) begin
            n_err++;
            $display("FAIL rd_data: got %h, expected %h", mem_dat, exp_d);
          end
        end
      end
      if (cpu_we && cpu_rdy) model[int'(cpu_addr)] = cpu_wdat;
      if (mem_addr_vld && mem_addr_gnt)
        exp_q.push_back(model.exists(int'(mem_addr)) ? model[int'(mem_addr)] : '0);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cpu_we   = 1'b1;
    cpu_addr = a;
    cpu_wdat = d;
    step();
    cpu_we   = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (cpu_rdy !== 1'b1 && cyc < 10000) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (mem_addr_gnt !== 1'b0) begin n_err++; $display("FAIL rst_gnt: got %b, expected 0", mem_addr_gnt); end
    n_vec++; if (mem_dat_vld !== 1'b0) begin n_err++; $display("FAIL rst_dat_vld: got %b, expected 0", mem_dat_vld); end
    n_vec++; if (mem_dat !== '0) begin n_err++; $display("FAIL rst_dat: got %h, expected 0000", mem_dat); end
    n_vec++; if (cpu_rdy !== 1'b0) begin n_err++; $display("FAIL rst_cpu_rdy: got %b, expected 0", cpu_rdy); end
    step();
    rstn = 1'b1;
    wait_ready(cyc);
    n_vec++; if (cpu_rdy !== 1'b1) begin n_err++; $display("FAIL rdy_timeout: cpu_rdy got %b, expected 1", cpu_rdy); end
    n_vec++; if (cyc != EXP_RDY_CYC) begin n_err++; $display("FAIL rdy_latency: got %0d cycles, expected %0d", cyc, EXP_RDY_CYC); end
  endtask

`ifdef SCREEN_MEM_CLEAR_EN
  task automatic test_clear();
    mem_dat_gnt  = 1'b1;
    mem_addr_vld = 1'b1;
    mem_addr     = 13'h1FFF;
    @(negedge clk);
    n_vec++; if (mem_addr_gnt !== 1'b1) begin n_err++; $display("FAIL clr_gnt: got %b, expected 1", mem_addr_gnt); end
    step();
    mem_addr_vld = 1'b0;
    @(negedge clk);
    n_vec++; if (mem_dat_vld !== 1'b1 || mem_dat !== 16'h0000) begin
      n_err++; $display("FAIL clr_data: got vld=%b dat=%h, expected vld=1 dat=0000", mem_dat_vld, mem_dat);
    end
    step();
  endtask
`endif

  task automatic test_write_read();
    cpu_write(13'h0010, 16'hBEEF);
    mem_dat_gnt  = 1'b1;
    mem_addr_vld = 1'b1;
    mem_addr     = 13'h0010;
    @(negedge clk);
    n_vec++; if (mem_addr_gnt !== 1'b1) begin n_err++; $display("FAIL wr_rd_gnt: got %b, expected 1", mem_addr_gnt); end
    n_vec++; if (mem_dat_vld !== 1'b0) begin n_err++; $display("FAIL wr_rd_early_vld: got %b, expected 0", mem_dat_vld); end
    step();
    mem_addr_vld = 1'b0;
    n_vec++; if (mem_dat_vld !== 1'b1 || mem_dat !== 16'hBEEF) begin
      n_err++; $display("FAIL wr_rd_data: got vld=%b dat=%h, expected vld=1 dat=beef", mem_dat_vld, mem_dat);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int vcnt;
    int first_k;
    int last_k;
    int gmiss;
    for (int i = 0; i < 8; i++) cpu_write(ADDR_W'(i), 16'hA000 + 16'(i * 16'h0111));
    mem_dat_gnt = 1'b1;
    vcnt = 0; first_k = -1; last_k = -1; gmiss = 0;
    for (int k = 0; k < 10; k++) begin
      mem_addr_vld = (k < 8);
      mem_addr     = ADDR_W'(k < 8 ? k : 0);
      @(negedge clk);
      if (k < 8 && mem_addr_gnt !== 1'b1) gmiss++;
      if (mem_dat_vld === 1'b1) begin
        vcnt++;
        if (first_k < 0) first_k = k;
        last_k = k;
      end
      step();
    end
    mem_addr_vld = 1'b0;
    n_vec++; if (gmiss != 0) begin n_err++; $display("FAIL b2b_gnt: %0d cycles without grant, expected 0", gmiss); end
    n_vec++; if (vcnt != 8 || first_k != 1 || last_k != 8) begin
      n_err++; $display("FAIL b2b_vld: got %0d valid cycles k=%0d..%0d, expected 8 cycles k=1..8", vcnt, first_k, last_k);
    end
  endtask

  task automatic test_backpressure();
    int grants;
    int pops0;
    logic g;
    logic have_first;
    logic stable_ok;
    logic [DATA_W-1:0] first;
    for (int i = 0; i < 16; i++) cpu_write(ADDR_W'(32 + i), 16'h5A00 + 16'(i));
    mem_dat_gnt  = 1'b0;
    mem_addr_vld = 1'b1;
    mem_addr     = 13'h0020;
    grants = 0; have_first = 1'b0; stable_ok = 1'b1; first = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      g = mem_addr_gnt;
      if (g === 1'b1) grants++;
      if (mem_dat_vld === 1'b1) begin
        if (!have_first) begin first = mem_dat; have_first = 1'b1; end
        else if (mem_dat !== first) stable_ok = 1'b0;
      end
      step();
      if (g === 1'b1) mem_addr = mem_addr + 13'd1;
    end
    n_vec++; if (grants != RSP_DEPTH) begin n_err++; $display("FAIL bp_grants: got %0d, expected %0d", grants, RSP_DEPTH); end
    n_vec++; if (!have_first || !stable_ok || first !== 16'h5A00) begin
      n_err++; $display("FAIL bp_stable: got first=%h stable=%b, expected 5a00 stable=1", first, stable_ok);
    end
    pops0 = n_pop;
    mem_addr_vld = 1'b0;
    mem_dat_gnt  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (mem_dat_vld === 1'b0 && exp_q.size() == 0) break;
      step();
    end
    n_vec++; if (exp_q.size() != 0 || n_pop - pops0 != RSP_DEPTH) begin
      n_err++; $display("FAIL bp_drain: got %0d pops with %0d left, expected %0d pops with 0 left", n_pop - pops0, exp_q.size(), RSP_DEPTH);
    end
  endtask

  task automatic test_collision();
    mem_dat_gnt  = 1'b1;
    cpu_we       = 1'b1;
    cpu_addr     = 13'h0040;
    cpu_wdat     = 16'h1234;
    mem_addr_vld = 1'b1;
    mem_addr     = 13'h0040;
    @(negedge clk);
    n_vec++; if (mem_addr_gnt !== 1'b0 || cpu_rdy !== 1'b1) begin
      n_err++; $display("FAIL coll_prio: got gnt=%b rdy=%b, expected gnt=0 rdy=1", mem_addr_gnt, cpu_rdy);
    end
    step();
    cpu_we = 1'b0;
    @(negedge clk);
    n_vec++; if (mem_addr_gnt !== 1'b1) begin n_err++; $display("FAIL coll_next_gnt: got %b, expected 1", mem_addr_gnt); end
    step();
    mem_addr_vld = 1'b0;
    @(negedge clk);
    n_vec++; if (mem_dat_vld !== 1'b1 || mem_dat !== 16'h1234) begin
      n_err++; $display("FAIL coll_data: got vld=%b dat=%h, expected vld=1 dat=1234", mem_dat_vld, mem_dat);
    end
    step();
  endtask

  task automatic test_reset_midop();
    int cyc;
    int stale;
    logic g;
    cpu_write(13'h0050, 16'hC0DE);
    cpu_write(13'h0051, 16'hF00D);
    mem_dat_gnt  = 1'b0;
    mem_addr_vld = 1'b1;
    mem_addr     = 13'h0050;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      g = mem_addr_gnt;
      step();
      if (g === 1'b1) mem_addr = mem_addr + 13'd1;
    end
    mem_addr_vld = 1'b0;
    @(negedge clk);
    n_vec++; if (mem_dat_vld !== 1'b1) begin n_err++; $display("FAIL midrst_setup: mem_dat_vld got %b, expected 1", mem_dat_vld); end
    #2 rstn = 1'b0;
    #1;
    n_vec++; if (mem_dat_vld !== 1'b0 || mem_dat !== '0) begin
      n_err++; $display("FAIL midrst_flush: got vld=%b dat=%h, expected vld=0 dat=0000", mem_dat_vld, mem_dat);
    end
    n_vec++; if (mem_addr_gnt !== 1'b0 || cpu_rdy !== 1'b0) begin
      n_err++; $display("FAIL midrst_ctrl: got gnt=%b rdy=%b, expected 0 0", mem_addr_gnt, cpu_rdy);
    end
    exp_q.delete();
    model.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    wait_ready(cyc);
    n_vec++; if (cpu_rdy !== 1'b1) begin n_err++; $display("FAIL midrst_rdy: got %b, expected 1", cpu_rdy); end
    mem_dat_gnt = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_dat_vld !== 1'b0) stale++;
    end
    n_vec++; if (stale != 0) begin n_err++; $display("FAIL midrst_stale: got %0d valid cycles, expected 0", stale); end
  endtask

  initial begin
    test_reset();
`ifdef SCREEN_MEM_CLEAR_EN
    test_clear();
`endif
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_collision();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/screen_mem_ctrl.md
SCREEN_MEM_CTRL -- requirements
Module: screen_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, 13, framebuffer word-address width (8192 words).
REQ-002 SHALL have parameter DATA_W, 16, framebuffer word width.
REQ-003 SHALL have parameter RSP_DEPTH, 2, response FIFO entries (min 2).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port cpu_we  input  1  CPU framebuffer write strobe.
REQ-007 SHALL have port cpu_addr  input  ADDR_W  CPU write address.
REQ-008 SHALL have port cpu_wdat  input  DATA_W  CPU write data.
REQ-009 SHALL have port cpu_rdy  output  1  high when CPU writes are accepted.
REQ-010 SHALL have port mem_addr_vld  input  1  SCREEN read request valid.
REQ-011 SHALL have port mem_addr_gnt  output  1  read request accepted.
REQ-012 SHALL have port mem_addr  input  ADDR_W  SCREEN read address.
REQ-013 SHALL have port mem_dat_vld  output  1  read data valid to SCREEN.
REQ-014 SHALL have port mem_dat_gnt  input  1  SCREEN accepts read data.
REQ-015 SHALL have port mem_dat  output  DATA_W  read data to SCREEN.

Function
REQ-016 SHALL hold an internal 2^ADDR_W x DATA_W single-port RAM, synchronous read, 1-cycle read latency.
REQ-017 SHALL treat a transfer as occurring only in a cycle with vld && gnt high on the same channel.
REQ-018 SHALL perform a CPU write in any cycle with cpu_we && cpu_rdy; cpu_we while cpu_rdy low is ignored.
REQ-019 SHALL give CPU writes priority: mem_addr_gnt low in any cycle with cpu_we high.
REQ-020 SHALL drive mem_addr_gnt high only when in RUN, cpu_we low, and (FIFO occupancy + reads in flight) < RSP_DEPTH.
REQ-021 SHALL push read data into the response FIFO one cycle after request acceptance; earliest mem_dat_vld is cycle N+1 for acceptance in N.
REQ-022 SHALL present FIFO head on mem_dat with mem_dat_vld = FIFO non-empty; pop on mem_dat_vld && mem_dat_gnt.
REQ-023 SHALL sustain one read per cycle when mem_dat_gnt held high and cpu_we low.
REQ-024 SHALL allow simultaneous push and pop on a full FIFO only through credit accounting; the FIFO never overflows.
REQ-025 SHALL return, for a read accepted the cycle after a write to the same address, the newly written data.
REQ-026 SHALL hold mem_dat stable while mem_dat_vld high and mem_dat_gnt low.
REQ-027 SHALL implement states INIT and RUN; INIT -> RUN when the init counter wraps from 2^ADDR_W-1; RUN is terminal until reset.

Reset
REQ-028 SHALL on rstn low force: mem_addr_gnt=0, mem_dat_vld=0, mem_dat=0, cpu_rdy=0, FIFO empty, in-flight count 0, init counter 0.
REQ-029 SHALL on reset mid-operation discard all in-flight and queued read data; RAM contents not guaranteed.
REQ-030 SHALL leave reset into INIT if SCREEN_MEM_CLEAR_EN defined, otherwise into RUN.

Configuration
REQ-031 SHALL, with SCREEN_MEM_CLEAR_EN defined, spend 2^ADDR_W cycles in INIT writing zero to addresses 0..2^ADDR_W-1 in order, cpu_rdy=0 and mem_addr_gnt=0 throughout.
REQ-032 SHALL, without SCREEN_MEM_CLEAR_EN, enter RUN one cycle after rstn deassert with cpu_rdy=1 and RAM contents undefined.

Structure
REQ-033 SHALL place ADDR_W/DATA_W defaults and the INIT/RUN state enum typedef in package screen_mem_pkg.
REQ-034 SHALL implement the response queue as sub-module screen_rsp_fifo (parameterised depth, width).

Verification
REQ-035 SHALL verify: CPU write 0xBEEF @0x0010, then SCREEN read 0x0010, mem_dat_gnt=1 -> mem_dat=0xBEEF, mem_dat_vld one cycle after grant.
REQ-036 SHALL verify: reads 0..7 back-to-back with mem_dat_gnt=1 -> 8 consecutive mem_dat_vld cycles, data in order.
REQ-037 SHALL verify: mem_dat_gnt=0 for 10 cycles with mem_addr_vld=1 -> exactly RSP_DEPTH grants, mem_dat stable, none lost on release.
REQ-038 SHALL verify: cpu_we and mem_addr_vld high same cycle -> write done, mem_addr_gnt=0, read granted next cycle.
REQ-039 SHALL verify (SCREEN_MEM_CLEAR_EN): after reset cpu_rdy rises after 8192 cycles; read 0x1FFF -> 0x0000.
REQ-040 SHALL verify: rstn pulsed low with 2 reads queued -> mem_dat_vld=0 immediately, no stale data after release.
